// File: rtl/ram_byte_loader_if.sv
// Byte-stream / RAM write-port bundle for ram_byte_loader.
// The loader connects through the slave modport, and the byte source / RAM side
// connects through the master modport.
interface ram_byte_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_ADDR  = 3,
   parameter int BYTE_WIDTH = 8
);
   logic [BYTE_WIDTH-1:0] byte_in;
   logic                  byte_valid;
   logic                  sof;
   logic                  byte_ready;
   logic [DATA_WIDTH-1:0] d_in;
   logic [DATA_ADDR-1:0]  wr_addr;
   logic                  we;
   logic [DATA_ADDR:0]    word_cnt;
   logic                  full;
   logic                  done;
   logic                  rd_release;

   modport master (
      output byte_in, byte_valid, sof, rd_release,
      input  byte_ready, d_in, wr_addr, we, word_cnt, full, done
   );

   modport slave (
      input  byte_in, byte_valid, sof, rd_release,
      output byte_ready, d_in, wr_addr, we, word_cnt, full, done
   );
endinterface

// File: rtl/ram_byte_loader.sv
// Write-side front end for the 8x16 dual-port RAM.
// Packs a framed byte stream into 16-bit words (low byte first) and writes them
// to consecutive RAM addresses. Once the buffer is full, it stops accepting bytes
// until the read side releases the buffer.
module ram_byte_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_DEPTH = 8,
   parameter int DATA_ADDR  = 3,
   parameter int BYTE_WIDTH = 8
) (
   input logic               wr_clk,
   input logic               clear,
   ram_byte_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GET_LO = 2'd1,
      GET_HI = 2'd2,
      FULL   = 2'd3
   } state_e;

   localparam logic [DATA_ADDR-1:0] PTR_ONE  = DATA_ADDR'(1);
   localparam logic [DATA_ADDR-1:0] PTR_LAST = DATA_ADDR'(DATA_DEPTH - 1);
   localparam logic [DATA_ADDR:0]   CNT_ONE  = (DATA_ADDR + 1)'(1);

   state_e                  state_q,    state_d;
   logic [BYTE_WIDTH-1:0]   lo_q,       lo_d;
   logic [DATA_ADDR-1:0]    ptr_q,      ptr_d;
   logic [DATA_WIDTH-1:0]   d_in_q,     d_in_d;
   logic [DATA_ADDR-1:0]    wr_addr_q,  wr_addr_d;
   logic                    we_q,       we_d;
   logic [DATA_ADDR:0]      word_cnt_q, word_cnt_d;
   logic                    full_q,     full_d;
   logic                    done_q,     done_d;
   logic                    accept;

   // Ready is the only combinational output, so the source sees backpressure in the same cycle.
   assign bus.byte_ready = (state_q != FULL) && !clear;
   assign accept         = bus.byte_valid && bus.byte_ready;

   assign bus.d_in     = d_in_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.we       = we_q;
   assign bus.word_cnt = word_cnt_q;
   assign bus.full     = full_q;
   assign bus.done     = done_q;

   // Next-state and next-output logic for the byte-pair packer.
   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      lo_d       = lo_q;
      ptr_d      = ptr_q;
      d_in_d     = d_in_q;
      wr_addr_d  = wr_addr_q;
      we_d       = 1'b0;
      word_cnt_d = word_cnt_q;
      full_d     = full_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept && bus.sof) begin
               lo_d       = bus.byte_in;
               ptr_d      = '0;
               word_cnt_d = '0;
               state_d    = GET_HI;
            end
         end
         GET_LO: begin
            if (accept) begin
               lo_d    = bus.byte_in;
               state_d = GET_HI;
               if (bus.sof) begin
                  ptr_d      = '0;
                  word_cnt_d = '0;
               end
            end
         end
         GET_HI: begin
            if (accept) begin
               if (bus.sof) begin
                  // A new frame starts here, so the pending low byte is dropped without a write.
                  lo_d       = bus.byte_in;
                  ptr_d      = '0;
                  word_cnt_d = '0;
               end else begin
                  d_in_d     = {bus.byte_in, lo_q};
                  wr_addr_d  = ptr_q;
                  we_d       = 1'b1;
                  word_cnt_d = word_cnt_q + CNT_ONE;
                  if (ptr_q == PTR_LAST) begin
                     full_d  = 1'b1;
                     done_d  = 1'b1;
                     state_d = FULL;
                  end else begin
                     ptr_d   = ptr_q + PTR_ONE;
                     state_d = GET_LO;
                  end
               end
            end
         end
         FULL: begin
            if (bus.rd_release) begin
               full_d     = 1'b0;
               word_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers. Clear is synchronous and takes priority over everything else.
   always_ff @(posedge wr_clk) begin
      // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
      if (clear) begin
         state_q    <= IDLE;
         lo_q       <= '0;
         ptr_q      <= '0;
         d_in_q     <= '0;
         wr_addr_q  <= '0;
         we_q       <= 1'b0;
         word_cnt_q <= '0;
         full_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         ptr_q      <= ptr_d;
         d_in_q     <= d_in_d;
         wr_addr_q  <= wr_addr_d;
         we_q       <= we_d;
         word_cnt_q <= word_cnt_d;
         full_q     <= full_d;
         done_q     <= done_d;
      end
   end

endmodule
